// File: rtl/numa_shared_mem_arbiter.sv
// Round-robin arbiter for the shared video-memory port of two MIPS cores; one access per grant.
// Define ARB_STATS_EN to build per-core saturating wait-cycle counters on wait_cnt0/wait_cnt1.
module numa_shared_mem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    a0,
  input  logic [DW-1:0]    wd0,
  output logic             ack0,
  output logic [DW-1:0]    rd0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    a1,
  input  logic [DW-1:0]    wd1,
  output logic             ack1,
  output logic [DW-1:0]    rd1,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DW-1:0]    mem_wd,
  input  logic [DW-1:0]    mem_rd,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] wait_cnt0,
  output logic [CNT_W-1:0] wait_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_t;

  state_t        state_q;
  logic          prio_q;
  logic          we_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] wd_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          mem_we_q;
  logic [1:0]    owner_q;

  logic          grant0_d;
  logic          grant1_d;

  // The served core's own req is ignored while leaving SERVEx; only the other core can follow.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant0_d = req0 && (!req1 || !prio_q);
        grant1_d = req1 && (!req0 ||  prio_q);
      end
      SERVE0:  grant1_d = req1;
      SERVE1:  grant0_d = req0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      a_q      <= '0;
      wd_q     <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_we_q <= 1'b0;
      owner_q  <= 2'b00;
    end else begin
      if (state_q == SERVE0) begin
        prio_q <= 1'b1;
      end else if (state_q == SERVE1) begin
        prio_q <= 1'b0;
      end

      if (grant0_d) begin
        state_q  <= SERVE0;
        we_q     <= we0;
        a_q      <= a0;
        wd_q     <= wd0;
        ack0_q   <= 1'b1;
        ack1_q   <= 1'b0;
        mem_we_q <= we0;
        owner_q  <= 2'b01;
      end else if (grant1_d) begin
        state_q  <= SERVE1;
        we_q     <= we1;
        a_q      <= a1;
        wd_q     <= wd1;
        ack0_q   <= 1'b0;
        ack1_q   <= 1'b1;
        mem_we_q <= we1;
        owner_q  <= 2'b10;
      end else begin
        state_q  <= IDLE;
        ack0_q   <= 1'b0;
        ack1_q   <= 1'b0;
        mem_we_q <= 1'b0;
        owner_q  <= 2'b00;
      end
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign mem_we = mem_we_q;
  assign mem_a  = a_q;
  assign mem_wd = wd_q;
  assign owner  = owner_q;

  // Memory read is asynchronous, so read data is steered straight from mem_rd during the grant.
  assign rd0 = (ack0_q && !we_q) ? mem_rd : '0;
  assign rd1 = (ack1_q && !we_q) ? mem_rd : '0;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] wcnt0_q;
  logic [CNT_W-1:0] wcnt0_d;
  logic [CNT_W-1:0] wcnt1_q;
  logic [CNT_W-1:0] wcnt1_d;

  always_comb begin
    wcnt0_d = wcnt0_q;
    wcnt1_d = wcnt1_q;
    if (req0 && !ack0_q && (wcnt0_q != '1)) begin
      wcnt0_d = wcnt0_q + CNT_W'(1);
    end
    if (req1 && !ack1_q && (wcnt1_q != '1)) begin
      wcnt1_d = wcnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt0_q <= '0;
      wcnt1_q <= '0;
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end

  assign wait_cnt0 = wcnt0_q;
  assign wait_cnt1 = wcnt1_q;
`else
  assign wait_cnt0 = '0;
  assign wait_cnt1 = '0;
`endif

endmodule

// File: tb/tb_numa_shared_mem_arbiter.sv
// Scoreboard bench for numa_shared_mem_arbiter: directed scenarios plus randomized two-core traffic.
`timescale 1ns/1ps
module tb_numa_shared_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, we0, req1, we1;
  logic [AW-1:0]    a0, a1;
  logic [DW-1:0]    wd0, wd1;
  logic             ack0, ack1;
  logic [DW-1:0]    rd0, rd1;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [DW-1:0]    mem_wd;
  logic [DW-1:0]    mem_rd;
  logic [1:0]       owner;
  logic [CNT_W-1:0] wait_cnt0, wait_cnt1;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            issue;
  } txn_t;

  typedef struct {
    int core;
    int cyc;
  } grant_t;

  txn_t          q0[$];
  txn_t          q1[$];
  grant_t        glog[$];
  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  int            exp_cnt0 = 0;
  int            exp_cnt1 = 0;
  txn_t          mt;
  bit            ok;

  numa_shared_mem_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .a0(a0), .wd0(wd0), .ack0(ack0), .rd0(rd0),
    .req1(req1), .we1(we1), .a1(a1), .wd1(wd1), .ack1(ack1), .rd1(rd1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .owner(owner), .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 32'hCAFE0001;
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  // Shared memory: asynchronous read, write committed at the clock edge.
  assign mem_rd = mem[mem_a[7:2]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected access whenever a core is acknowledged.
  always @(negedge clk) begin
    if (reset) begin
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end
    check("wait_cnt0", wait_cnt0, STATS ? exp_cnt0 : 0);
    check("wait_cnt1", wait_cnt1, STATS ? exp_cnt1 : 0);
    check("ack_exclusive", ack0 & ack1, 0);
    if (ack0 || ack1) begin
      if ((ack0 && q0.size() == 0) || (!ack0 && q1.size() == 0)) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with no request outstanding", ack0, ack1);
      end else begin
        if (ack0) mt = q0.pop_front();
        else      mt = q1.pop_front();
        check("owner", owner, ack0 ? 2'b01 : 2'b10);
        check("mem_a", mem_a, mt.a);
        check("mem_we", mem_we, mt.we);
        if (mt.we) begin
          check("mem_wd", mem_wd, mt.wd);
          ref_mem[mt.a[7:2]] = mt.wd;
        end else begin
          check("rd_data", ack0 ? rd0 : rd1, ref_mem[mt.a[7:2]]);
        end
        n_vec++;
        if (cyc - mt.issue < 1 || cyc - mt.issue > 3) begin
          n_bad++;
          $display("FAIL grant_latency: got %0d cycles required 1..3", cyc - mt.issue);
        end
        glog.push_back('{ack0 ? 0 : 1, cyc});
      end
    end else begin
      check("idle_ctrl", {owner, mem_we}, 0);
      check("idle_rd", {rd0, rd1}, 0);
    end
    if (!reset) begin
      if (req0 && !ack0 && exp_cnt0 != int'(CNT_MAX)) exp_cnt0++;
      if (req1 && !ack1 && exp_cnt1 != int'(CNT_MAX)) exp_cnt1++;
    end
  end

  task automatic issue(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    txn_t t;
    t.we = we; t.a = a; t.wd = wd; t.issue = cyc;
    if (c == 0) begin
      we0 = we; a0 = a; wd0 = wd; req0 = 1'b1;
      q0.push_back(t);
    end else begin
      we1 = we; a1 = a; wd1 = wd; req1 = 1'b1;
      q1.push_back(t);
    end
  endtask

  task automatic rand_issue(input int c);
    logic [AW-1:0] a;
    a = AW'($urandom_range(255));
    issue(c, 1'($urandom_range(1)), a, $urandom);
  endtask

  task automatic drop(input int c);
    if (c == 0) begin
      req0 = 1'b0; we0 = 1'($urandom); a0 = $urandom; wd0 = $urandom;
    end else begin
      req1 = 1'b0; we1 = 1'($urandom); a1 = $urandom; wd1 = $urandom;
    end
  endtask

  // Called just after a rising edge: a served core either drops req or presents a new access.
  task automatic drive_step(input int p_new, input int p_cont);
    logic r, k;
    for (int c = 0; c < 2; c++) begin
      r = (c == 0) ? req0 : req1;
      k = (c == 0) ? ack0 : ack1;
      if (r && k) begin
        if (int'($urandom_range(99)) < p_cont) rand_issue(c);
        else drop(c);
      end else if (!r) begin
        if (int'($urandom_range(99)) < p_new) rand_issue(c);
      end
    end
  endtask

  task automatic wait_ack(input int c, output bit got);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if ((c == 0) ? ack0 : ack1) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL ack_timeout: core%0d got no ack required one within 6 cycles", c);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      drive_step(0, 0);
      if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1) break;
    end
    @(posedge clk); #1;
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {ack0, ack1, mem_we, owner}, 0);
    check("rst_addr_data", {mem_a, mem_wd}, 0);
    check("rst_rd", {rd0, rd1}, 0);
    @(negedge clk); #1 reset = 1'b0;

    // Single read of word 4.
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_ack(0, ok);
    check("read_word4", rd0, 32'hCAFE0001);
    check("read_owner", {owner, ack1}, 3'b010);
    req0 = 1'b0;

    // Write through core 1, then read back through core 0.
    @(posedge clk); #1;
    issue(1, 1'b1, 32'h20, 32'h12345678);
    wait_ack(1, ok);
    check("write_strobe", {mem_we, mem_a}, {1'b1, 32'h20});
    req1 = 1'b0;
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_ack(0, ok);
    check("readback", rd0, 32'h12345678);
    req0 = 1'b0;

    // Requester address changes during its ack cycle.
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_ack(0, ok);
    a0 = 32'h30;
    req0 = 1'b0;
    #1 check("addr_frozen", mem_a, 32'h10);

    // Reset in the middle of a core 1 write.
    @(posedge clk); #1;
    issue(1, 1'b1, 32'h40, 32'hDEADBEEF);
    wait_ack(1, ok);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_ack1", ack1, 0);
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_owner", owner, 0);
    req1 = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    check("rst_mid_word", mem[16], ref_mem[16]);
    @(negedge clk); #1 reset = 1'b0;

    // Continuous contention from reset.
    @(posedge clk); #1;
    glog.delete();
    rand_issue(0);
    rand_issue(1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        check("cnt0_after10", wait_cnt0, STATS ? 5 : 0);
        check("cnt1_after10", wait_cnt1, STATS ? 6 : 0);
        drive_step(0, 0);
      end else begin
        drive_step(0, 100);
      end
    end
    drain();
    check("grant_count", glog.size(), 11);
    for (int i = 0; i < glog.size() && i < 11; i++) begin
      check("grant_order", glog[i].core, i % 2);
      if (i > 0) check("grant_gap", glog[i].cyc - glog[i-1].cyc, 1);
    end

    // Randomized two-core traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      drive_step(35, 40);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/numa_shared_mem_arbiter.md
Name: numa_shared_mem_arbiter

Overview:
- Arbitrates the single shared video-memory port (async read, sync write) between two MIPS cores in the NUMA system.
- Each core's local memory stays private. Only accesses decoded as shared by core-side glue reach this block.
- Two-requester round-robin with a request/ack handshake and one access per grant.
- Drives the shared memory's we/a/wd and returns read data to the winning core.

Parameters:
- AW, 32, address width on requester and memory ports
- DW, 32, data width
- CNT_W, 16, width of optional wait-cycle counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  core 0 access request, held until ack0
- we0  in  1  core 0 write enable (1=write, 0=read)
- a0  in  AW  core 0 byte address
- wd0  in  DW  core 0 write data
- ack0  out  1  one-cycle completion strobe to core 0
- rd0  out  DW  read data to core 0, valid only while ack0=1, else 0
- req1/we1/a1/wd1/ack1/rd1  same as core 0, for core 1
- mem_we  out  1  shared memory write enable
- mem_a  out  AW  shared memory address
- mem_wd  out  DW  shared memory write data
- mem_rd  in  DW  shared memory read data (combinational from mem_a)
- owner  out  2  00 idle, 01 core 0 served, 10 core 1 served
- wait_cnt0  out  CNT_W  core 0 stall counter (see Optional Feature)
- wait_cnt1  out  CNT_W  core 1 stall counter (see Optional Feature)

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - On reset: state=IDLE, prio=0, latched a/we/wd=0.
  - All outputs reset to 0: ack0, ack1, mem_we, mem_a, mem_wd, owner, rd0, rd1.
- FSM states are IDLE, SERVE0 and SERVE1.
- IDLE:
  - If exactly one req is high, latch that core's a/we/wd and go to SERVEx.
  - If both reqs are high, pick the core equal to prio and latch its signals.
  - If neither is high, stay in IDLE.
- SERVEx:
  - mem_a and mem_wd come from the latched registers.
  - mem_we = latched we.
  - ackx=1 and owner=one-hot x.
  - On a read, rdx = mem_rd.
  - A write commits at the clock edge that ends SERVEx.
- Latency: a request first sampled at edge N gives ack in the cycle after edge N. One access per ack.
- Leaving SERVEx:
  - Set prio = other core.
  - If the other core's req is high, latch the other core's signals and go to SERVEother (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE.
- The served core's req is ignored during its own ack cycle. The core must drop req or present a new request afterwards; a new request is sampled from IDLE.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. Maximum wait is 2 cycles after a request is sampled.
- Latched signals are frozen for the whole grant. Requester changes during SERVEx have no effect.
- Unused low address bits pass through unmodified; the memory does word alignment.
- Reset mid-SERVE: state goes to IDLE immediately and ack/mem_we drop asynchronously. The pending write is not committed.

Optional Feature:
- Macro: ARB_STATS_EN.
- With the macro defined, each core has a CNT_W-bit saturating counter:
  - Increments on every cycle where reqx=1 and ackx=0.
  - Saturates at all-ones.
  - Cleared by reset only.
  - Drives wait_cntx.
- Without the macro, no counter logic is built and wait_cnt0/wait_cnt1 are tied to 0. Port list is unchanged.

Test Plan:
- Single read: core 0 req, a0=0x10, mem word4=0xCAFE0001 -> ack0 high one cycle later with rd0=0xCAFE0001, owner=01, ack1=0.
- Single write: core 1 we1=1, a1=0x20, wd1=0x12345678 -> mem_we=1 and mem_a=0x20 during ack1; a read back through core 0 returns 0x12345678.
- Simultaneous req0/req1 from reset (prio=0) with both held -> ack0, ack1, ack0, ack1 on consecutive cycles with no IDLE cycle between.
- Requester changes a0 from 0x10 to 0x30 during its ack cycle -> mem_a stays 0x10 for that access.
- Reset asserted during a SERVE1 write -> ack1 and mem_we drop without waiting for a clock edge; memory word unchanged; owner=00.
- ARB_STATS_EN with both cores requesting continuously for 10 cycles from reset -> wait_cnt0=5 and wait_cnt1=6 (core 0 waits on its first sampled cycle and each cycle core 1 is served).
